text_renderer: RTL and testbench
================================

Name: text_renderer

Overview:
Parametrised text-mode pixel engine; successor to the fixed 64x16, 8x16 character renderer inside the top level.
- Converts sync-generator blanking into character-buffer and char-ROM addresses, then serialises glyph rows to a 1-bit video stream.
- Adds configurable cursor shape/blink, out-of-range blanking and a fixed, documented pipeline latency.
- Sits between sync_generator, char_buffer, char_rom and cursor_position/cursor_blinker.

Parameters:
- COLS, 80, text columns per line
- ROWS, 24, text rows per frame
- CHAR_W, 8, glyph width in pixels (rom_data width)
- CHAR_H, 16, glyph height in scanlines
- CODE_W, 8, character code width (buffer_rdata width)
- ADDR_W, 11, buffer address width; requires COLS*ROWS <= 2**ADDR_W
- UL_ROWS, 2, underline cursor height in scanlines

Ports:
- px_clk, in, 1, pixel clock
- clr, in, 1, reset; asynchronous, active-high
- hblank, in, 1, horizontal blanking from sync_generator
- vblank, in, 1, vertical blanking from sync_generator
- cursor_x, in, clog2(COLS), cursor column
- cursor_y, in, clog2(ROWS), cursor row
- cursor_mode, in, 2, 0 off / 1 blinking block / 2 blinking underline / 3 steady block
- cursor_blink_on, in, 1, blink phase from cursor_blinker
- buffer_ren, out, 1, buffer read enable
- buffer_raddr, out, ADDR_W, buffer read address
- buffer_rdata, in, CODE_W, character code; synchronous read, valid one cycle after address
- rom_addr, out, CODE_W+clog2(CHAR_H), {code, scanline}
- rom_data, in, CHAR_W, glyph row; MSB is leftmost pixel; valid one cycle after address
- video, out, 1, pixel output
- hblank_out, out, 1, hblank delayed to align with video
- vblank_out, out, 1, vblank delayed to align with video

Behaviour:
Reset (clr=1):
- All counters 0.
- video=0, hblank_out=1, vblank_out=1, buffer_ren=0.
- Pipeline valid bits cleared.
- Reset takes effect immediately mid-frame.

Scan counters (sub-pixel colc, col, scanline rowc, row, line_base):
- active = ~hblank & ~vblank.
- vblank: all counters and line_base <= 0; line_seen <= 0.
- active: line_seen <= 1; colc++. At colc==CHAR_W-1: colc <= 0; col++, saturating at COLS.
- First hblank cycle with line_seen=1 (once per line): line_seen <= 0; col, colc <= 0. If rowc==CHAR_H-1: rowc <= 0, row++ saturating at ROWS, line_base += COLS (no add once row==ROWS). Else rowc++.

Stage 0 (cycle t, combinational from counters):
- buffer_raddr = line_base + col.
- in_range = active & col<COLS & row<ROWS.
- buffer_ren = in_range.

Stage 1 (t+1):
- rom_addr = {buffer_rdata, rowc_d1}.
- colc, in_range, cursor hit and blank flags carried in registers.

Stage 2 (t+2):
- pix = rom_data[CHAR_W-1-colc_d2].

Output register (t+3):
- video = in_range_d2 & (pix ^ cur).
- hblank_out/vblank_out = inputs delayed 3 cycles.
- Total latency from blanking inputs to video is exactly 3 px_clk.

Cursor (evaluated at stage 0, then pipelined):
- hit = col==cursor_x & row==cursor_y.
- cur = hit & (mode==3 | (mode==1 & blink_on) | (mode==2 & blink_on & rowc>=CHAR_H-UL_ROWS)). Mode 0 never inverts.
- cursor_x>=COLS or cursor_y>=ROWS never hits.
- cursor inputs are sampled per pixel; a change takes effect on the next pixel.

Boundaries:
- Active pixels beyond COLS*CHAR_W or rows beyond ROWS output 0 with no buffer read.
- vblank asserted mid-line restarts the frame.
- hblank without a preceding active pixel does not advance the scanline.

Optional Feature:
TEXT_RENDERER_ATTR_EN
- Defined: buffer_rdata MSB is the reverse-video attribute. rom_addr code field = {1'b0, buffer_rdata[CODE_W-2:0]}. The pixel is additionally XORed with the attribute, pipelined alongside pix. Cursor XOR still applies on top.
- Undefined: full code goes to the ROM; no attribute.

Decomposition:
- Package vt_video_pkg holds the cursor-mode constants (CUR_OFF, CUR_BLOCK, CUR_UNDERLINE, CUR_STEADY) and the pipeline latency constant RENDER_LAT=3.
- One sub-module, text_scan_counter: scan counters, line_base, in_range and buffer address.
- text_renderer instantiates it plus the 3-stage pixel/cursor pipeline.

Test Plan:
Bench parameters: COLS=4, ROWS=2, CHAR_W=8, CHAR_H=4, behavioural RAM and ROM, ROM row = code.
- Line 0, buffer[0..3]=0x81,0x00,0xFF,0x0F: video = 10000001 00000000 11111111 00001111, exactly 3 cycles after hblank falls.
- 8 scanlines: buffer_raddr is 0..3 for scanlines 0-3 and 4..7 for scanlines 4-7; rom_addr scanline field cycles 0,1,2,3.
- Active line 48 px wide: pixels 32-47 give video=0 and buffer_ren=0.
- cursor (1,0), mode 1, blink_on=1: pixels 8-15 inverted on all 4 scanlines. Mode 2: inverted only on scanlines 2-3. blink_on=0 with mode 1: no inversion. Mode 3 with blink_on=0: inverted.
- clr pulsed mid-line: video=0, hblank_out=1 at once. After release, the next vblank then active period restarts at buffer_raddr 0.
- ATTR_EN, buffer[0]=0x81 with ROM(0x01)=0x0F: video = 11110000.

Source files
------------

// File: rtl/vt_video_pkg.sv
// Shared constants for the text-mode video path: cursor modes, render latency
// and a width helper that never returns zero.
package vt_video_pkg;

    localparam logic [1:0] CUR_OFF       = 2'd0;
    localparam logic [1:0] CUR_BLOCK     = 2'd1;
    localparam logic [1:0] CUR_UNDERLINE = 2'd2;
    localparam logic [1:0] CUR_STEADY    = 2'd3;

    localparam int RENDER_LAT = 3;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/text_scan_counter.sv
// Character/scanline position tracker: turns blanking into column, row and
// sub-character counters, the current line's buffer base and the read address.
module text_scan_counter
    import vt_video_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 24,
    parameter int CHAR_W = 8,
    parameter int CHAR_H = 16,
    parameter int ADDR_W = 11
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_hblank,
    input  logic                                i_vblank,
    output logic [clog2_min1(CHAR_W)-1:0]       o_colc,
    output logic [clog2_min1(CHAR_H)-1:0]       o_rowc,
    output logic [clog2_min1(COLS + 1)-1:0]     o_col,
    output logic [clog2_min1(ROWS + 1)-1:0]     o_row,
    output logic                                o_in_range,
    output logic [ADDR_W-1:0]                   o_raddr
);

    localparam int CC_W  = clog2_min1(CHAR_W);
    localparam int RC_W  = clog2_min1(CHAR_H);
    localparam int COL_W = clog2_min1(COLS + 1);
    localparam int ROW_W = clog2_min1(ROWS + 1);

    logic              w_active;
    logic              r_line_seen;
    logic [CC_W-1:0]   r_colc;
    logic [RC_W-1:0]   r_rowc;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_line_base;

    assign w_active = ~i_hblank & ~i_vblank;

    // Counters describe the pixel on the inputs now; they move on the edge.
    // col and row saturate one past the text area so out-of-range pixels stay dark.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line_seen <= 1'b0;
            r_colc      <= '0;
            r_rowc      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
        end else if (i_vblank) begin
            r_line_seen <= 1'b0;
            r_colc      <= '0;
            r_rowc      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
        end else if (w_active) begin
            r_line_seen <= 1'b1;
            if (r_colc == CC_W'(CHAR_W - 1)) begin
                r_colc <= '0;
                if (r_col != COL_W'(COLS)) begin
                    r_col <= r_col + COL_W'(1);
                end else begin
                    r_col <= r_col;
                end
            end else begin
                r_colc <= r_colc + CC_W'(1);
            end
        end else if (r_line_seen) begin
            r_line_seen <= 1'b0;
            r_colc      <= '0;
            r_col       <= '0;
            if (r_rowc == RC_W'(CHAR_H - 1)) begin
                r_rowc <= '0;
                if (r_row != ROW_W'(ROWS)) begin
                    r_row       <= r_row + ROW_W'(1);
                    r_line_base <= r_line_base + ADDR_W'(COLS);
                end else begin
                    r_row       <= r_row;
                    r_line_base <= r_line_base;
                end
            end else begin
                r_rowc <= r_rowc + RC_W'(1);
            end
        end else begin
            r_line_seen <= r_line_seen;
        end
    end

    assign o_colc     = r_colc;
    assign o_rowc     = r_rowc;
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_in_range = w_active & ~i_rst & (r_col < COL_W'(COLS)) & (r_row < ROW_W'(ROWS));
    assign o_raddr    = r_line_base + ADDR_W'(r_col);

endmodule

// File: rtl/text_renderer.sv
// Text-mode pixel engine: scan counters, buffer/ROM fetch and a 3-stage pixel
// pipeline with cursor overlay. Define TEXT_RENDERER_ATTR_EN for reverse-video attribute.
module text_renderer
    import vt_video_pkg::*;
#(
    parameter int COLS    = 80,
    parameter int ROWS    = 24,
    parameter int CHAR_W  = 8,
    parameter int CHAR_H  = 16,
    parameter int CODE_W  = 8,
    parameter int ADDR_W  = 11,
    parameter int UL_ROWS = 2
) (
    input  logic                                  px_clk,
    input  logic                                  clr,
    input  logic                                  hblank,
    input  logic                                  vblank,
    input  logic [clog2_min1(COLS)-1:0]           cursor_x,
    input  logic [clog2_min1(ROWS)-1:0]           cursor_y,
    input  logic [1:0]                            cursor_mode,
    input  logic                                  cursor_blink_on,
    output logic                                  buffer_ren,
    output logic [ADDR_W-1:0]                     buffer_raddr,
    input  logic [CODE_W-1:0]                     buffer_rdata,
    output logic [CODE_W+clog2_min1(CHAR_H)-1:0]  rom_addr,
    input  logic [CHAR_W-1:0]                     rom_data,
    output logic                                  video,
    output logic                                  hblank_out,
    output logic                                  vblank_out
);

    localparam int CC_W  = clog2_min1(CHAR_W);
    localparam int RC_W  = clog2_min1(CHAR_H);
    localparam int COL_W = clog2_min1(COLS + 1);
    localparam int ROW_W = clog2_min1(ROWS + 1);

    logic [CC_W-1:0]   w_colc;
    logic [RC_W-1:0]   w_rowc;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_hit;
    logic              w_ul_zone;
    logic              w_cur;
    logic [CODE_W-1:0] w_code;
    logic              w_attr;
    logic              w_pix;

    logic [CC_W-1:0]   r_colc_d1;
    logic [RC_W-1:0]   r_rowc_d1;
    logic              r_in_range_d1;
    logic              r_cur_d1;
    logic [CC_W-1:0]   r_colc_d2;
    logic              r_in_range_d2;
    logic              r_cur_d2;
    logic              r_attr_d2;
    logic              r_video;
    logic [RENDER_LAT-1:0] r_hb_dly;
    logic [RENDER_LAT-1:0] r_vb_dly;

    text_scan_counter #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .i_clk      (px_clk),
        .i_rst      (clr),
        .i_hblank   (hblank),
        .i_vblank   (vblank),
        .o_colc     (w_colc),
        .o_rowc     (w_rowc),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_in_range (w_in_range),
        .o_raddr    (w_raddr)
    );

    assign buffer_ren   = w_in_range;
    assign buffer_raddr = w_raddr;

    // Cursor decision for the pixel currently on the inputs.
    always_comb begin
        w_hit     = 1'b0;
        w_ul_zone = 1'b0;
        w_cur     = 1'b0;
        w_hit     = (int'(w_col) == int'(cursor_x)) && (int'(w_row) == int'(cursor_y)) &&
                    (int'(cursor_x) < COLS) && (int'(cursor_y) < ROWS);
        w_ul_zone = (int'(w_rowc) >= (CHAR_H - UL_ROWS));
        case (cursor_mode)
            CUR_OFF:       w_cur = 1'b0;
            CUR_BLOCK:     w_cur = w_hit & cursor_blink_on;
            CUR_UNDERLINE: w_cur = w_hit & cursor_blink_on & w_ul_zone;
            CUR_STEADY:    w_cur = w_hit;
            default:       w_cur = 1'b0;
        endcase
    end

    // Stage 1: buffer data arrives; carry position and cursor alongside it.
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            r_colc_d1     <= '0;
            r_rowc_d1     <= '0;
            r_in_range_d1 <= 1'b0;
            r_cur_d1      <= 1'b0;
        end else begin
            r_colc_d1     <= w_colc;
            r_rowc_d1     <= w_rowc;
            r_in_range_d1 <= w_in_range;
            r_cur_d1      <= w_cur;
        end
    end

`ifdef TEXT_RENDERER_ATTR_EN
    assign w_code = {1'b0, buffer_rdata[CODE_W-2:0]};
    assign w_attr = buffer_rdata[CODE_W-1];
`else
    assign w_code = buffer_rdata;
    assign w_attr = 1'b0;
`endif

    assign rom_addr = {w_code, r_rowc_d1};

    // Stage 2: glyph row arrives; the attribute travels with it.
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            r_colc_d2     <= '0;
            r_in_range_d2 <= 1'b0;
            r_cur_d2      <= 1'b0;
            r_attr_d2     <= 1'b0;
        end else begin
            r_colc_d2     <= r_colc_d1;
            r_in_range_d2 <= r_in_range_d1;
            r_cur_d2      <= r_cur_d1;
            r_attr_d2     <= w_attr;
        end
    end

    assign w_pix = rom_data[CC_W'(CHAR_W - 1) - r_colc_d2];

    // Output register plus blanking delay lines matched to the pixel latency.
    always_ff @(posedge px_clk or posedge clr) begin
        if (clr) begin
            r_video  <= 1'b0;
            r_hb_dly <= '1;
            r_vb_dly <= '1;
        end else begin
            r_video  <= r_in_range_d2 & (w_pix ^ r_attr_d2 ^ r_cur_d2);
            r_hb_dly <= {r_hb_dly[RENDER_LAT-2:0], hblank};
            r_vb_dly <= {r_vb_dly[RENDER_LAT-2:0], vblank};
        end
    end

    assign video      = r_video;
    assign hblank_out = r_hb_dly[RENDER_LAT-1];
    assign vblank_out = r_vb_dly[RENDER_LAT-1];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer (COLS=4, ROWS=2, CHAR_W=8, CHAR_H=4).
// Reference model works in pixel/scanline coordinates and a 3-deep expectation queue.
module tb_text_renderer;

    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int CHAR_W  = 8;
    localparam int CHAR_H  = 4;
    localparam int CODE_W  = 8;
    localparam int ADDR_W  = 11;
    localparam int UL_ROWS = 2;

    logic        px_clk = 1'b0;
    logic        clr = 1'b1;
    logic        hblank = 1'b1;
    logic        vblank = 1'b1;
    logic [1:0]  cursor_x = 2'd0;
    logic        cursor_y = 1'b0;
    logic [1:0]  cursor_mode = 2'd0;
    logic        cursor_blink_on = 1'b0;
    logic        buffer_ren;
    logic [10:0] buffer_raddr;
    logic [7:0]  buffer_rdata = 8'h00;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        video;
    logic        hblank_out;
    logic        vblank_out;

    text_renderer #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
        .CODE_W(CODE_W), .ADDR_W(ADDR_W), .UL_ROWS(UL_ROWS)
    ) dut (
        .px_clk(px_clk), .clr(clr), .hblank(hblank), .vblank(vblank),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_mode(cursor_mode),
        .cursor_blink_on(cursor_blink_on), .buffer_ren(buffer_ren),
        .buffer_raddr(buffer_raddr), .buffer_rdata(buffer_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data), .video(video),
        .hblank_out(hblank_out), .vblank_out(vblank_out)
    );

    always #5 px_clk = ~px_clk;

    logic [7:0] mem [0:7];
    logic [7:0] rom_tbl [0:255];

    always @(posedge px_clk) begin
        if (buffer_ren) buffer_rdata <= mem[buffer_raddr[2:0]];
        rom_data <= rom_tbl[rom_addr[9:2]];
    end

    typedef struct {
        logic vid;
        logic hb;
        logic vb;
        logic act;
        int   x;
        int   y;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        logic [7:0] exp_byte;
    } line_vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       blink;
        logic [3:0] inv;
    } cur_vec_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         mx, my;
    logic       seen;
    logic       prev_rom_v;
    logic [9:0] prev_rom;
    logic       rand_cursor = 1'b0;
    logic       cap [0:7][0:47];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_t e;
        e.vid = 1'b0; e.hb = 1'b1; e.vb = 1'b1; e.act = 1'b0; e.x = -1; e.y = -1;
        q.delete();
        repeat (3) q.push_back(e);
        mx = 0; my = 0; seen = 1'b0; prev_rom_v = 1'b0; prev_rom = '0;
    endtask

    // One pixel clock: drive inputs, predict, then compare at the falling edge.
    task automatic tick(input logic hb, input logic vb);
        logic act, inr, pixb, curb, attrb, mrule;
        int col, row, colc, rowc, addr;
        logic [7:0] code, ceff;
        exp_t e, f;
        @(posedge px_clk); #1;
        if (rand_cursor && ($urandom_range(0, 7) == 0)) begin
            cursor_x        = 2'($urandom_range(0, 3));
            cursor_y        = 1'($urandom_range(0, 1));
            cursor_mode     = 2'($urandom_range(0, 3));
            cursor_blink_on = 1'($urandom_range(0, 1));
        end
        hblank = hb; vblank = vb;
        act  = !hb && !vb;
        col  = mx / CHAR_W; colc = mx % CHAR_W;
        row  = my / CHAR_H; rowc = my % CHAR_H;
        inr  = act && (col < COLS) && (row < ROWS);
        addr = row * COLS + col;
        if (inr) code = mem[addr];
        else code = 8'h00;
`ifdef TEXT_RENDERER_ATTR_EN
        ceff = {1'b0, code[6:0]}; attrb = code[7];
`else
        ceff = code; attrb = 1'b0;
`endif
        pixb = rom_tbl[ceff][7 - colc];
        if (cursor_mode == 2'd3) mrule = 1'b1;
        else if (cursor_mode == 2'd1) mrule = cursor_blink_on;
        else if (cursor_mode == 2'd2) mrule = cursor_blink_on && (rowc >= CHAR_H - UL_ROWS);
        else mrule = 1'b0;
        curb = (col == int'(cursor_x)) && (row == int'(cursor_y)) && mrule;
        e.vid = inr & (pixb ^ attrb ^ curb);
        e.hb = hb; e.vb = vb; e.act = act; e.x = mx; e.y = my;
        q.push_back(e);

        @(negedge px_clk);
        chk("buffer_ren", 32'(buffer_ren), 32'(inr));
        if (inr) chk("buffer_raddr", 32'(buffer_raddr), 32'(addr));
        if (prev_rom_v) chk("rom_addr", 32'(rom_addr), 32'(prev_rom));
        prev_rom_v = inr;
        prev_rom   = {ceff, 2'(rowc)};
        f = q.pop_front();
        chk("video", 32'(video), 32'(f.vid));
        chk("hblank_out", 32'(hblank_out), 32'(f.hb));
        chk("vblank_out", 32'(vblank_out), 32'(f.vb));
        if (f.act && f.y >= 0 && f.y < 8 && f.x >= 0 && f.x < 48) cap[f.y][f.x] = video;

        if (vb) begin
            mx = 0; my = 0; seen = 1'b0;
        end else if (act) begin
            mx++; seen = 1'b1;
        end else if (seen) begin
            seen = 1'b0; mx = 0; my++;
        end
    endtask

    task automatic run_frame(input int nlines, input int act_len, input int hb_len);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 48; x++) cap[y][x] = 1'bx;
        repeat (3) tick(1'b1, 1'b1);
        for (int l = 0; l < nlines; l++) begin
            repeat (act_len) tick(1'b0, 1'b0);
            repeat (hb_len) tick(1'b1, 1'b0);
        end
        repeat (4) tick(1'b1, 1'b1);
    endtask

    function automatic logic [7:0] get_byte(input int s, input int c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = cap[s][c * 8 + i];
        return b;
    endfunction

    line_vec_t lvec [0:3];
    cur_vec_t  cvec [0:5];

    initial begin
        int nl, al;
        logic [15:0] tail;

        for (int i = 0; i < 256; i++) rom_tbl[i] = 8'(i);
`ifdef TEXT_RENDERER_ATTR_EN
        rom_tbl[1] = 8'h0F;
        lvec[0] = '{8'h81, 8'hF0}; lvec[1] = '{8'h00, 8'h00};
        lvec[2] = '{8'hFF, 8'h80}; lvec[3] = '{8'h0F, 8'h0F};
`else
        lvec[0] = '{8'h81, 8'h81}; lvec[1] = '{8'h00, 8'h00};
        lvec[2] = '{8'hFF, 8'hFF}; lvec[3] = '{8'h0F, 8'h0F};
`endif
        cvec[0] = '{2'd1, 1'b1, 4'b1111};
        cvec[1] = '{2'd2, 1'b1, 4'b1100};
        cvec[2] = '{2'd1, 1'b0, 4'b0000};
        cvec[3] = '{2'd3, 1'b0, 4'b1111};
        cvec[4] = '{2'd0, 1'b1, 4'b0000};
        cvec[5] = '{2'd2, 1'b0, 4'b0000};

        // Reset with active-looking inputs: outputs must sit at reset values.
        clr = 1'b1; hblank = 1'b0; vblank = 1'b0;
        repeat (2) @(posedge px_clk);
        #1;
        chk("rst_video", 32'(video), 32'd0);
        chk("rst_hblank_out", 32'(hblank_out), 32'd1);
        chk("rst_vblank_out", 32'(vblank_out), 32'd1);
        chk("rst_buffer_ren", 32'(buffer_ren), 32'd0);
        hblank = 1'b1; vblank = 1'b1;
        @(posedge px_clk); #1;
        clr = 1'b0;
        model_reset();

        // Line-0 glyph pattern and 8-scanline addressing.
        for (int i = 0; i < 4; i++) mem[i] = lvec[i].code;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h44; mem[7] = 8'h18;
        run_frame(8, 32, 4);
        for (int c = 0; c < 4; c++) chk($sformatf("line0_char%0d", c), 32'(get_byte(0, c)), 32'(lvec[c].exp_byte));

        // 48-pixel lines: the overhang stays dark.
        run_frame(8, 48, 4);
        for (int y = 0; y < 8; y++) begin
            for (int i = 0; i < 16; i++) tail[i] = cap[y][32 + i];
            chk($sformatf("overhang_line%0d", y), 32'(tail), 32'd0);
        end

        // Cursor shapes on column 1, row 0.
        mem[1] = 8'h3C;
        cursor_x = 2'd1; cursor_y = 1'b0;
        for (int v = 0; v < 6; v++) begin
            cursor_mode = cvec[v].mode; cursor_blink_on = cvec[v].blink;
            run_frame(4, 32, 4);
            for (int s = 0; s < 4; s++)
                chk($sformatf("cursor_v%0d_s%0d", v, s), 32'(get_byte(s, 1)),
                    32'(8'h3C ^ (cvec[v].inv[s] ? 8'hFF : 8'h00)));
        end

        // Reset pulsed mid-line.
        cursor_mode = 2'd3; cursor_x = 2'd0; cursor_y = 1'b0;
        repeat (3) tick(1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b0);
        @(posedge px_clk); #1;
        clr = 1'b1;
        #1;
        chk("midclr_video", 32'(video), 32'd0);
        chk("midclr_hblank_out", 32'(hblank_out), 32'd1);
        chk("midclr_vblank_out", 32'(vblank_out), 32'd1);
        chk("midclr_buffer_ren", 32'(buffer_ren), 32'd0);
        hblank = 1'b1; vblank = 1'b1;
        repeat (2) @(posedge px_clk);
        #1;
        clr = 1'b0;
        model_reset();
        repeat (2) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        chk("restart_raddr", 32'(buffer_raddr), 32'd0);
        repeat (31) tick(1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b0);

        // Randomized frames with per-pixel cursor changes and stray vblanks.
        rand_cursor = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            repeat ($urandom_range(1, 3)) tick(1'b1, 1'b1);
            nl = $urandom_range(0, 11);
            for (int l = 0; l < nl; l++) begin
                al = $urandom_range(0, 48);
                for (int p = 0; p < al; p++) begin
                    if ($urandom_range(0, 399) == 0) tick(1'b0, 1'b1);
                    else tick(1'b0, 1'b0);
                end
                repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0);
            end
        end
        repeat (4) tick(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
